// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/trap controller.
package pipe_ctrl_pkg;

  // PC source select driven to the fetch stage
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2,
    PC_MEPC   = 2'd3
  } pc_sel_e;

  // Trap sequencing states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SAVE  = 2'd2,
    FLUSH = 2'd3
  } hz_state_e;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive memory-stall cycles and raises a sticky timeout flag.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mstall,
  output logic timeout_err
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             hit_c;

  // The increment that lands on WAIT_MAX (or any stall once saturated) trips the flag
  assign hit_c = mstall & (wait_cnt >= CNT_W'(WAIT_MAX - 1));

  // Saturating consecutive-stall counter, cleared by any advancing cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!mstall) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_W'(WAIT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if (hit_c) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: memory waits, load-use, branches, trap entry and mret.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned WAIT_MAX  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       im_req,
  input  logic       im_ready,
  input  logic       dm_req,
  input  logic       dm_ready,
  input  logic [4:0] ID_rs1_addr,
  input  logic [4:0] ID_rs2_addr,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic [4:0] EX_write_addr,
  input  logic       EX_is_load,
  input  logic       EX_branch_taken,
  input  logic       EX_mret,
  input  logic       irq_pending,
  output logic       im_stall,
  output logic       dm_stall,
  output logic       CSR_stall,
  output logic       CSR_reset,
  output logic       pc_hold,
  output logic       IFID_stall,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic [1:0] pc_sel,
  output logic       trap_save,
  output logic       timeout_err
);

  localparam int unsigned DCNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  hz_state_e          state_q, state_d;
  logic [DCNT_W-1:0]  drain_q, drain_d;
  pc_sel_e            sel_q, sel_d;

  logic               mstall;
  logic               load_use_c;
  logic               csr_stall_c, csr_reset_c, pc_hold_c, ifid_stall_c;
  logic               ifid_flush_c, idex_flush_c, trap_save_c;
  pc_sel_e            pc_sel_c;

  // Memory handshake stalls
  assign im_stall = im_req & ~im_ready;
  assign dm_stall = dm_req & ~dm_ready;
  assign mstall   = im_stall | dm_stall;

  // Load-use hazard against the EX destination; x0 never hazards
  assign load_use_c = EX_is_load & (EX_write_addr != 5'd0) &
                      ((ID_uses_rs1 & (ID_rs1_addr == EX_write_addr)) |
                       (ID_uses_rs2 & (ID_rs2_addr == EX_write_addr)));

  // State, drain counter and latched PC select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      drain_q <= '0;
      sel_q   <= PC_PLUS4;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    sel_d        = sel_q;
    csr_stall_c  = 1'b0;
    csr_reset_c  = 1'b0;
    pc_hold_c    = 1'b0;
    ifid_stall_c = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    trap_save_c  = 1'b0;
    pc_sel_c     = PC_PLUS4;
    unique case (state_q)
      RUN: begin
        if (!mstall) begin
          if (irq_pending) begin
            state_d = DRAIN;
            drain_d = DCNT_W'(DRAIN_CYC);
          end else if (EX_mret) begin
            state_d = FLUSH;
            sel_d   = PC_MEPC;
          end else if (EX_branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            pc_sel_c     = PC_BRANCH;
          end else if (load_use_c) begin
            pc_hold_c    = 1'b1;
            ifid_stall_c = 1'b1;
            idex_flush_c = 1'b1;
          end
        end
      end
      DRAIN: begin
        pc_hold_c    = 1'b1;
        ifid_stall_c = 1'b1;
        idex_flush_c = 1'b1;
        if (!mstall) begin
          // The advancing cycle that takes the count to zero is the last drain cycle
          if (drain_q <= DCNT_W'(1)) begin
            drain_d = '0;
            state_d = SAVE;
          end else begin
            drain_d = drain_q - DCNT_W'(1);
          end
        end
      end
      SAVE: begin
        csr_stall_c = 1'b1;
        trap_save_c = 1'b1;
        pc_hold_c   = 1'b1;
        if (!mstall) begin
          state_d = FLUSH;
          sel_d   = PC_TRAP;
        end
      end
      FLUSH: begin
        csr_reset_c  = 1'b1;
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        pc_sel_c     = sel_q;
        if (!mstall) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Controls are forced low while reset is held
  assign CSR_stall  = reset & csr_stall_c;
  assign CSR_reset  = reset & csr_reset_c;
  assign pc_hold    = reset & pc_hold_c;
  assign IFID_stall = reset & ifid_stall_c;
  assign IFID_flush = reset & ifid_flush_c;
  assign IDEX_flush = reset & idex_flush_c;
  assign trap_save  = reset & trap_save_c;
  assign pc_sel     = reset ? pc_sel_c : PC_PLUS4;

  stall_watchdog #(
    .WAIT_MAX(WAIT_MAX)
  ) u_stall_watchdog (
    .clk        (clk),
    .reset      (reset),
    .mstall     (mstall),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a queue-based reference model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned WAIT_MAX  = 255;

  // model step codes for the pending trap/mret sequence
  localparam int PH_DRAIN = 1, PH_SAVE = 2, PH_FLUSH_TRAP = 3, PH_FLUSH_MRET = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       im_req, im_ready, dm_req, dm_ready;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, EX_write_addr;
  logic       ID_uses_rs1, ID_uses_rs2, EX_is_load, EX_branch_taken, EX_mret, irq_pending;
  logic       im_stall, dm_stall, CSR_stall, CSR_reset, pc_hold, IFID_stall;
  logic       IFID_flush, IDEX_flush, trap_save, timeout_err;
  logic [1:0] pc_sel;

  int n_checks = 0;
  int n_errors = 0;
  int seq_q[$];
  int consec = 0;
  bit tout = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_ready(im_ready), .dm_req(dm_req), .dm_ready(dm_ready),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_write_addr(EX_write_addr), .EX_is_load(EX_is_load),
    .EX_branch_taken(EX_branch_taken), .EX_mret(EX_mret), .irq_pending(irq_pending),
    .im_stall(im_stall), .dm_stall(dm_stall), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
    .pc_hold(pc_hold), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .pc_sel(pc_sel), .trap_save(trap_save),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    im_req = 0; im_ready = 0; dm_req = 0; dm_ready = 0;
    ID_rs1_addr = 0; ID_rs2_addr = 0; ID_uses_rs1 = 0; ID_uses_rs2 = 0;
    EX_write_addr = 0; EX_is_load = 0; EX_branch_taken = 0; EX_mret = 0; irq_pending = 0;
  endtask

  // Compare every output with what the model expects for the current inputs
  task automatic check_outputs();
    logic e_ims, e_dms, mst, lu;
    logic e_cst, e_crst, e_hold, e_ifs, e_iff, e_idf, e_ts;
    logic [1:0] e_sel;
    e_ims = im_req & ~im_ready;
    e_dms = dm_req & ~dm_ready;
    mst   = e_ims | e_dms;
    lu = EX_is_load && EX_write_addr != 0 &&
         ((ID_uses_rs1 && ID_rs1_addr == EX_write_addr) ||
          (ID_uses_rs2 && ID_rs2_addr == EX_write_addr));
    {e_cst, e_crst, e_hold, e_ifs, e_iff, e_idf, e_ts} = '0;
    e_sel = 2'd0;
    if (reset) begin
      if (seq_q.size() == 0) begin
        if (!mst && !irq_pending && !EX_mret) begin
          if (EX_branch_taken) begin
            e_iff = 1; e_idf = 1; e_sel = 2'd1;
          end else if (lu) begin
            e_hold = 1; e_ifs = 1; e_idf = 1;
          end
        end
      end else begin
        case (seq_q[0])
          PH_DRAIN:      begin e_hold = 1; e_ifs = 1; e_idf = 1; end
          PH_SAVE:       begin e_cst = 1; e_ts = 1; e_hold = 1; end
          PH_FLUSH_TRAP: begin e_crst = 1; e_iff = 1; e_idf = 1; e_sel = 2'd2; end
          default:       begin e_crst = 1; e_iff = 1; e_idf = 1; e_sel = 2'd3; end
        endcase
      end
    end
    check("im_stall", 32'(im_stall), 32'(e_ims));
    check("dm_stall", 32'(dm_stall), 32'(e_dms));
    check("CSR_stall", 32'(CSR_stall), 32'(e_cst));
    check("CSR_reset", 32'(CSR_reset), 32'(e_crst));
    check("pc_hold", 32'(pc_hold), 32'(e_hold));
    check("IFID_stall", 32'(IFID_stall), 32'(e_ifs));
    check("IFID_flush", 32'(IFID_flush), 32'(e_iff));
    check("IDEX_flush", 32'(IDEX_flush), 32'(e_idf));
    check("trap_save", 32'(trap_save), 32'(e_ts));
    check("pc_sel", 32'(pc_sel), 32'(e_sel));
    check("timeout_err", 32'(timeout_err), 32'(reset ? tout : 1'b0));
  endtask

  // Advance the model by one clock using the inputs sampled at the edge
  task automatic model_update();
    logic mst;
    mst = (im_req & ~im_ready) | (dm_req & ~dm_ready);
    if (!reset) begin
      seq_q.delete();
      consec = 0;
      tout = 0;
      return;
    end
    consec = mst ? consec + 1 : 0;
    if (consec >= int'(WAIT_MAX)) tout = 1;
    if (mst) return;
    if (seq_q.size() != 0) begin
      void'(seq_q.pop_front());
    end else if (irq_pending) begin
      for (int i = 0; i < int'(DRAIN_CYC); i++) seq_q.push_back(PH_DRAIN);
      seq_q.push_back(PH_SAVE);
      seq_q.push_back(PH_FLUSH_TRAP);
    end else if (EX_mret) begin
      seq_q.push_back(PH_FLUSH_MRET);
    end
  endtask

  // One cycle: inputs already applied after a negedge
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Idle until the model has no pending sequence (bounded)
  task automatic settle();
    clear_inputs();
    for (int i = 0; i < 20 && seq_q.size() != 0; i++) step();
    check("settle_idle", 32'(seq_q.size()), 32'd0);
  endtask

  // IRQ pulse, return cycle numbers of trap_save and CSR_reset (optionally one im stall in DRAIN)
  task automatic run_irq(input bit inject, output int ts_cyc, output int cr_cyc, output int cr_sel);
    ts_cyc = -1; cr_cyc = -1; cr_sel = -1;
    for (int k = 0; k < 16; k++) begin
      clear_inputs();
      irq_pending = (k == 0);
      if (inject && k == 2) begin im_req = 1; im_ready = 0; end
      #1;
      if (trap_save && ts_cyc < 0) ts_cyc = k;
      if (CSR_reset && cr_cyc < 0) begin cr_cyc = k; cr_sel = int'(pc_sel); end
      step();
    end
  endtask

  initial begin
    int ts, cr, cs;
    clear_inputs();
    reset = 0;
    @(negedge clk);
    step();
    step();
    reset = 1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      im_req          = 1'($urandom_range(0, 1));
      im_ready        = ($urandom_range(0, 3) != 0);
      dm_req          = 1'($urandom_range(0, 1));
      dm_ready        = ($urandom_range(0, 3) != 0);
      ID_rs1_addr     = 5'($urandom_range(0, 3));
      ID_rs2_addr     = 5'($urandom_range(0, 3));
      ID_uses_rs1     = 1'($urandom_range(0, 1));
      ID_uses_rs2     = 1'($urandom_range(0, 1));
      EX_write_addr   = 5'($urandom_range(0, 3));
      EX_is_load      = 1'($urandom_range(0, 1));
      EX_branch_taken = ($urandom_range(0, 3) == 0);
      EX_mret         = ($urandom_range(0, 24) == 0);
      irq_pending     = ($urandom_range(0, 24) == 0);
      step();
    end
    settle();

    // Load-use on rs2, then x0 destination
    EX_is_load = 1; EX_write_addr = 5'd5; ID_rs2_addr = 5'd5; ID_uses_rs2 = 1;
    #1;
    check("lu_pc_hold", 32'(pc_hold), 32'd1);
    check("lu_idex_flush", 32'(IDEX_flush), 32'd1);
    step();
    clear_inputs();
    #1;
    check("lu_one_cycle", 32'(pc_hold), 32'd0);
    step();
    EX_is_load = 1; EX_write_addr = 5'd0; ID_rs2_addr = 5'd0; ID_uses_rs2 = 1;
    #1;
    check("lu_x0_no_stall", 32'(pc_hold), 32'd0);
    step();

    // Branch held by a data-memory stall
    clear_inputs();
    EX_branch_taken = 1; dm_req = 1; dm_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("br_dm_stall", 32'(dm_stall), 32'd1);
      check("br_held_flush", 32'(IFID_flush), 32'd0);
      step();
    end
    dm_ready = 1;
    #1;
    check("br_flush", 32'(IDEX_flush), 32'd1);
    check("br_pc_sel", 32'(pc_sel), 32'd1);
    step();

    // IRQ latency without and with a stall during drain
    run_irq(1'b0, ts, cr, cs);
    check("irq_save_cycle", 32'(ts), 32'd4);
    check("irq_flush_cycle", 32'(cr), 32'd5);
    check("irq_flush_sel", 32'(cs), 32'd2);
    settle();
    run_irq(1'b1, ts, cr, cs);
    check("irq_stall_save_cycle", 32'(ts), 32'd5);
    check("irq_stall_flush_cycle", 32'(cr), 32'd6);
    settle();

    // mret with a concurrent branch
    clear_inputs();
    EX_mret = 1; EX_branch_taken = 1;
    #1;
    check("mret_no_br_flush", 32'(IFID_flush), 32'd0);
    step();
    clear_inputs();
    #1;
    check("mret_csr_reset", 32'(CSR_reset), 32'd1);
    check("mret_pc_sel", 32'(pc_sel), 32'd3);
    step();
    settle();

    // Watchdog boundary and stickiness
    clear_inputs();
    im_req = 1; im_ready = 0;
    for (int i = 0; i < int'(WAIT_MAX) - 1; i++) step();
    #1;
    check("wd_below_max", 32'(timeout_err), 32'd0);
    step();
    #1;
    check("wd_at_max", 32'(timeout_err), 32'd1);
    im_ready = 1;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("wd_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in the middle of DRAIN
    clear_inputs();
    irq_pending = 1;
    step();
    clear_inputs();
    step();
    #2;
    reset = 0;
    #1;
    check("rst_pc_hold", 32'(pc_hold), 32'd0);
    check("rst_idex_flush", 32'(IDEX_flush), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    step();
    reset = 1;
    EX_branch_taken = 1;
    #1;
    check("rst_run_branch", 32'(IFID_flush), 32'd1);
    check("rst_run_sel", 32'(pc_sel), 32'd1);
    step();
    clear_inputs();
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
